demux8_buf: RTL and testbench
=============================

DEMUX8_BUF -- requirements
Module: demux8_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-006 SHALL have port in_data, input, DATA_WIDTH bits: the upstream payload.
REQ-007 SHALL have port in_sel, input, 3 bits: the destination channel index, 0..7.
REQ-008 SHALL have ports out_data0..out_data7, output, DATA_WIDTH bits each: the per-channel registered payload.
REQ-009 SHALL have port out_valid, output, 8 bits: bit k means channel k holds a word.
REQ-010 SHALL have port out_ready, input, 8 bits: bit k means the channel k consumer takes the word.
REQ-011 SHALL have port bcast, input, 1 bit: broadcast request; present only when DEMUX8_BCAST_EN is defined.

Function
REQ-012 SHALL hold one-entry buffer per channel; state per channel EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
REQ-013 SHALL complete an input transfer on a cycle where in_valid && in_ready; a channel transfer on a cycle where out_valid[k] && out_ready[k].
REQ-014 SHALL drive in_ready = !out_valid[in_sel] || out_ready[in_sel], combinationally, without depending on in_valid.
REQ-015 SHALL, on an input transfer, load in_data into out_data[in_sel] and set out_valid[in_sel]=1 at the next edge; latency exactly 1 cycle.
REQ-016 SHALL, on a channel transfer with no same-cycle load to that channel, clear out_valid[k] at the next edge; out_data[k] retains its last value.
REQ-017 SHALL, on a simultaneous drain and load of the same channel, keep out_valid[k]=1 and replace out_data[k] with the new word, with no bubble and no loss.
REQ-018 SHALL leave all channels other than in_sel unaffected by an input transfer; drains on different channels are independent and may all occur in one cycle.
REQ-019 SHALL NOT change out_data[k] while out_valid[k]=1 and out_ready[k]=0, so the output stays stable under backpressure.
REQ-020 SHALL ignore in_sel and in_data whenever in_valid=0.
REQ-021 SHALL contain no combinational path from in_data to out_data*; outputs are registered.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, force out_valid=8'h00 and every out_data*=0, regardless of other inputs.
REQ-023 SHALL, when rst is asserted mid-operation, discard all buffered words; a handshake in the reset cycle has no effect.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst is released, because all channels are EMPTY.

Configuration
REQ-025 SHALL implement the broadcast feature only when macro DEMUX8_BCAST_EN is defined.
REQ-026 SHALL, with DEMUX8_BCAST_EN defined and bcast=1, drive in_ready = AND over k of (!out_valid[k] || out_ready[k]), ignoring in_sel.
REQ-027 SHALL, on a broadcast transfer, load in_data into all eight channels and set out_valid=8'hFF at the next edge.
REQ-028 SHALL, without DEMUX8_BCAST_EN, omit the bcast port and all broadcast logic, leaving behaviour exactly as in REQ-012..REQ-021.

Verification
REQ-029 SHALL cover: after reset, in_valid=1, in_sel=3, in_data=32'hDEADBEEF -> next cycle out_valid=8'h08 and out_data3=32'hDEADBEEF.
REQ-030 SHALL cover: channel 5 full with out_ready[5]=0, in_sel=5 -> in_ready=0 and out_data5 holds for 10 cycles; out_ready[5]=1 -> in_ready=1 in the same cycle.
REQ-031 SHALL cover: channel 2 full with 32'h1, out_ready[2]=1, new word 32'h2 to sel=2 -> out_valid[2] stays 1 and out_data2=32'h2 next cycle.
REQ-032 SHALL cover: channels 0..7 filled in 8 consecutive cycles, then out_ready=8'hFF for 1 cycle -> out_valid=8'h00 the following cycle.
REQ-033 SHALL cover: rst=1 asserted with out_valid=8'hA5 -> out_valid=8'h00 and all out_data*=0 next cycle.
REQ-034 SHALL cover, with DEMUX8_BCAST_EN: bcast=1, in_data=32'h55AA55AA, channel 6 full and not ready -> in_ready=0; out_ready[6]=1 -> out_valid=8'hFF next cycle with all outputs 32'h55AA55AA.

Source files
------------

// File: rtl/demux8_buf.sv
// -----------------------------------------------------------------------------
// demux8_buf
//   1-to-8 demultiplexer with a one-entry buffer on each output channel.
//   An upstream word selected by in_sel is written into that channel's buffer.
//   Each buffer drains independently through its own valid/ready handshake.
//   A full channel that is being drained in the same cycle can take a new word
//   with no bubble. All outputs are registered. in_ready is combinational from
//   the buffer state and out_ready, and does not depend on in_valid.
//
//   Optional feature (macro DEMUX8_BCAST_EN):
//     Adds the bcast input. While bcast=1 the word goes to all eight channels.
//     It is accepted only when every channel can take it.
//
// Ports
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           upstream word valid
//   in_ready   out  1           upstream word accepted this cycle
//   in_data    in   DATA_WIDTH  upstream payload
//   in_sel     in   3           destination channel 0..7
//   bcast      in   1           broadcast request (DEMUX8_BCAST_EN only)
//   out_data0..out_data7
//              out  DATA_WIDTH  per-channel registered payload
//   out_valid  out  8           bit k: channel k holds a word
//   out_ready  in   8           bit k: channel k consumer takes the word
// -----------------------------------------------------------------------------
module demux8_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_sel,
`ifdef DEMUX8_BCAST_EN
  input  logic                  bcast,
`endif
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic [DATA_WIDTH-1:0] out_data4,
  output logic [DATA_WIDTH-1:0] out_data5,
  output logic [DATA_WIDTH-1:0] out_data6,
  output logic [DATA_WIDTH-1:0] out_data7,
  output logic [7:0]            out_valid,
  input  logic [7:0]            out_ready
);

  logic [7:0]            valid_q;
  logic [7:0]            valid_d;
  logic [DATA_WIDTH-1:0] data_q [8];
  logic [DATA_WIDTH-1:0] data_d [8];

  logic [7:0]            ch_free;    // channel can take a word this cycle
  logic [7:0]            load_mask;  // channels written at the next edge
  logic [7:0]            drain_mask; // channels emptied by their consumer
  logic                  in_ready_c;

  // Acceptance decision and the channels that a transfer writes
  always_comb begin
    // A full channel is free when its consumer drains it in the same cycle.
    ch_free    = ~valid_q | out_ready;
    in_ready_c = 1'b0;
    load_mask  = 8'h00;
`ifdef DEMUX8_BCAST_EN
    if (bcast) begin
      in_ready_c = &ch_free;
    end else begin
      in_ready_c = ch_free[in_sel];
    end
    if (in_valid && in_ready_c) begin
      if (bcast) begin
        load_mask = 8'hFF;
      end else begin
        load_mask = 8'h01 << in_sel;
      end
    end else begin
      load_mask = 8'h00;
    end
`else
    in_ready_c = ch_free[in_sel];
    if (in_valid && in_ready_c) begin
      load_mask = 8'h01 << in_sel;
    end else begin
      load_mask = 8'h00;
    end
`endif
  end

  // Next buffer state: drain clears valid, a load sets it and has priority
  always_comb begin
    drain_mask = valid_q & out_ready;
    valid_d    = (valid_q & ~drain_mask) | load_mask;
    for (int k = 0; k < 8; k++) begin
      if (load_mask[k]) begin
        data_d[k] = in_data;
      end else begin
        data_d[k] = data_q[k];
      end
    end
  end

  // Buffer registers with synchronous reset that discards all held words
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_data4 = data_q[4];
  assign out_data5 = data_q[5];
  assign out_data6 = data_q[6];
  assign out_data7 = data_q[7];

endmodule

// File: tb/tb_demux8_buf.sv
// -----------------------------------------------------------------------------
// tb_demux8_buf
//   Self-checking bench for demux8_buf (DATA_WIDTH=32).
//   A vector table holds hand-derived in_ready and out_valid values. A
//   reference model of the eight buffers pushes the expected next state into a
//   queue when stimulus is driven. The queue is popped and compared after the
//   clock edge. Hand-written sequences cover backpressure, fill/drain-all, and
//   mid-operation reset. They also cover broadcast when DEMUX8_BCAST_EN is
//   defined.
// -----------------------------------------------------------------------------
module tb_demux8_buf;

  typedef struct packed {
    logic [7:0]       valid;
    logic [7:0][31:0] data;
  } exp_t;

  typedef struct {
    logic        iv;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        bcast;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [31:0] out_data4, out_data5, out_data6, out_data7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;

  logic [7:0][31:0] dut_data;
  assign dut_data = {out_data7, out_data6, out_data5, out_data4,
                     out_data3, out_data2, out_data1, out_data0};

  // reference model and scoreboard
  logic [7:0]       m_valid;
  logic [7:0][31:0] m_data;
  logic             m_known = 1'b0;
  exp_t             sb_q [$];
  logic             last_rdy;
  int               errors = 0;
  int               checks = 0;

  demux8_buf #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DEMUX8_BCAST_EN
    .bcast     (bcast),
`endif
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_data4 (out_data4),
    .out_data5 (out_data5),
    .out_data6 (out_data6),
    .out_data7 (out_data7),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check in_ready, advance model, compare after edge
  task automatic step(input logic r, input logic iv, input logic [2:0] sel,
                      input logic [31:0] d, input logic [7:0] ordy, input logic bc);
    logic       exp_rdy;
    logic [7:0] free;
    logic [7:0] load;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    rst = r; in_valid = iv; in_sel = sel; in_data = d; out_ready = ordy; bcast = bc;
    #1;
    last_rdy = in_ready;
    free = ~m_valid | ordy;
`ifdef DEMUX8_BCAST_EN
    exp_rdy = bc ? (&free) : free[sel];
`else
    exp_rdy = free[sel];
`endif
    if (m_known) chk("in_ready", {255'd0, in_ready}, {255'd0, exp_rdy});
    if (r) begin
      m_valid = 8'h00;
      m_data  = '0;
      m_known = 1'b1;
    end else begin
      load = 8'h00;
      if (iv && exp_rdy) begin
`ifdef DEMUX8_BCAST_EN
        load = bc ? 8'hFF : (8'h01 << sel);
`else
        load = 8'h01 << sel;
`endif
      end
      m_valid = (m_valid & ~(m_valid & ordy)) | load;
      for (int k = 0; k < 8; k++) if (load[k]) m_data[k] = d;
    end
    e.valid = m_valid;
    e.data  = m_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("out_valid", {248'd0, out_valid}, {248'd0, got.valid});
    chk("out_data", dut_data, got.data);
  endtask

  initial begin
    vec_t tbl [10];
    tbl[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 8'h00, 1'b1, 8'h08};
    tbl[1] = '{1'b0, 3'd3, 32'h00001234, 8'h00, 1'b0, 8'h08};
    tbl[2] = '{1'b1, 3'd3, 32'h00001111, 8'h00, 1'b0, 8'h08};
    tbl[3] = '{1'b1, 3'd0, 32'h000000A0, 8'h00, 1'b1, 8'h09};
    tbl[4] = '{1'b1, 3'd7, 32'h000000A7, 8'h08, 1'b1, 8'h81};
    tbl[5] = '{1'b1, 3'd7, 32'h000000B7, 8'h80, 1'b1, 8'h81};
    tbl[6] = '{1'b0, 3'd0, 32'h00000000, 8'hFF, 1'b1, 8'h00};
    tbl[7] = '{1'b1, 3'd2, 32'h00000001, 8'h00, 1'b1, 8'h04};
    tbl[8] = '{1'b1, 3'd2, 32'h00000002, 8'h04, 1'b1, 8'h04};
    tbl[9] = '{1'b1, 3'd5, 32'h000000C5, 8'h04, 1'b1, 8'h20};

    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 32'd0;
    out_ready = 8'h00; bcast = 1'b0;
    m_valid = 8'h00; m_data = '0;

    // reset state, then in_ready must be 1 once released
    step(1'b1, 1'b0, 3'd0, 32'd0, 8'h00, 1'b0);
    chk("reset_valid", {248'd0, out_valid}, 256'd0);
    chk("reset_data", dut_data, 256'd0);

    // table vectors (first row is the single-word load of channel 3)
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl%0d_rdy", i), {255'd0, last_rdy}, {255'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_ov", i), {248'd0, out_valid}, {248'd0, tbl[i].exp_ov});
    end
    chk("tbl9_data2", {224'd0, out_data2}, {224'd0, 32'h00000002});

    // backpressure on channel 5 (already full with C5): 10 held cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 3'd5, 32'h5000_0000 + i, 8'h00, 1'b0);
      chk("bp_rdy", {255'd0, last_rdy}, 256'd0);
      chk("bp_hold", {224'd0, out_data5}, {224'd0, 32'h000000C5});
    end
    step(1'b0, 1'b1, 3'd5, 32'h0000D5D5, 8'h20, 1'b0);
    chk("bp_release_rdy", {255'd0, last_rdy}, 256'd1);
    chk("bp_release_data", {224'd0, out_data5}, {224'd0, 32'h0000D5D5});

    // fill all eight channels in consecutive cycles, then drain all at once
    step(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, k[2:0], 32'hF000_0000 + k, 8'h00, 1'b0);
    end
    chk("fill_all", {248'd0, out_valid}, {248'd0, 8'hFF});
    step(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF, 1'b0);
    chk("drain_all", {248'd0, out_valid}, 256'd0);
    chk("drain_keeps_data", {224'd0, out_data6}, {224'd0, 32'hF0000006});

    // build out_valid=A5, then reset with a handshake offered in the reset cycle
    step(1'b0, 1'b1, 3'd0, 32'h11111111, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'd2, 32'h22222222, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'd5, 32'h55555555, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'd7, 32'h77777777, 8'h00, 1'b0);
    chk("pre_reset_ov", {248'd0, out_valid}, {248'd0, 8'hA5});
    step(1'b1, 1'b1, 3'd1, 32'h99999999, 8'h00, 1'b0);
    chk("mid_reset_ov", {248'd0, out_valid}, 256'd0);
    chk("mid_reset_data", dut_data, 256'd0);
    step(1'b0, 1'b0, 3'd4, 32'd0, 8'h00, 1'b0);
    chk("post_reset_rdy", {255'd0, last_rdy}, 256'd1);

`ifdef DEMUX8_BCAST_EN
    // broadcast blocked by full, stalled channel 6, then released
    step(1'b0, 1'b1, 3'd6, 32'h00006666, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'd1, 32'h55AA55AA, 8'h00, 1'b1);
    chk("bc_blocked_rdy", {255'd0, last_rdy}, 256'd0);
    chk("bc_blocked_ov", {248'd0, out_valid}, {248'd0, 8'h40});
    step(1'b0, 1'b1, 3'd1, 32'h55AA55AA, 8'h40, 1'b1);
    chk("bc_rdy", {255'd0, last_rdy}, 256'd1);
    chk("bc_ov", {248'd0, out_valid}, {248'd0, 8'hFF});
    chk("bc_data", dut_data, {8{32'h55AA55AA}});
`endif

    if (sb_q.size() != 0) chk("sb_empty", 256'(sb_q.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
